// File: rtl/alu_issue_ctrl.sv
// Issue controller for alu_16bit_low_power: one operation in flight, single-cycle enable
// pulse to the ALU, result and flags returned over a valid/ready response channel.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// ISSUE  | alu_en high for one cycle with operands driven
// WAIT   | operands isolated, down-counter covers ALU latency
// RESP   | rsp_valid high until rsp_ready
module alu_issue_ctrl #(
    parameter int DATA_W  = 16,
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [DATA_W-1:0] req_a_i,
    input  logic [DATA_W-1:0] req_b_i,
    input  logic [2:0]        req_op_i,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic [2:0]        alu_op_o,
    output logic              alu_en_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_carry_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_result_o,
    output logic              rsp_zero_o,
    output logic              rsp_carry_o,
    output logic [CNT_W-1:0]  op_count_o
);

    localparam int WCNT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state_q;
    logic                req_ready_q;
    logic [DATA_W-1:0]   alu_a_q;
    logic [DATA_W-1:0]   alu_b_q;
    logic [2:0]          alu_op_q;
    logic                alu_en_q;
    logic [WCNT_W-1:0]   wait_cnt_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_result_q;
    logic                rsp_zero_q;
    logic                rsp_carry_q;
    logic [CNT_W-1:0]    op_count_q;
    logic [CNT_W-1:0]    op_count_d;
    logic                accept;

    assign accept = (state_q == S_IDLE) && req_valid_i && req_ready_q;

    // Saturating: the counter sticks at all-ones instead of wrapping.
    always_comb begin
        op_count_d = op_count_q;
        if (op_count_q != {CNT_W{1'b1}}) begin
            op_count_d = op_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            alu_en_q     <= 1'b0;
            wait_cnt_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_carry_q  <= 1'b0;
            op_count_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        alu_a_q     <= req_a_i;
                        alu_b_q     <= req_b_i;
                        alu_op_q    <= req_op_i;
                        alu_en_q    <= 1'b1;
                        req_ready_q <= 1'b0;
                        op_count_q  <= op_count_d;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    alu_en_q   <= 1'b0;
                    alu_a_q    <= '0;
                    alu_b_q    <= '0;
                    wait_cnt_q <= WCNT_W'(ALU_LAT);
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt_q == '0) begin
                        // Zero flag is derived from the captured data, not the ALU's flag.
                        rsp_result_q <= alu_result_i;
                        rsp_carry_q  <= alu_carry_i;
                        rsp_zero_q   <= (alu_result_i == '0);
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - WCNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    alu_en_q    <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o  = req_ready_q;
    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign alu_op_o     = alu_op_q;
    assign alu_en_o     = alu_en_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_zero_o   = rsp_zero_q;
    assign rsp_carry_o  = rsp_carry_q;
    assign op_count_o   = op_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: stand-in ALU, queue-based reference model, directed and random ops.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic [2:0]  req_op = '0;
    logic [15:0] alu_result = '0;
    logic        alu_carry = 1'b0;

    logic        req_ready, alu_en, rsp_valid, rsp_zero, rsp_carry;
    logic [15:0] alu_a, alu_b, rsp_result, op_count;
    logic [2:0]  alu_op;

    logic        req_ready4, alu_en4, rsp_valid4, rsp_zero4, rsp_carry4;
    logic [15:0] alu_a4, alu_b4, rsp_result4;
    logic [2:0]  alu_op4;
    logic [3:0]  op_count4;

    alu_issue_ctrl dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b), .req_op_i(req_op),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op), .alu_en_o(alu_en),
        .alu_result_i(alu_result), .alu_carry_i(alu_carry),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
        .rsp_zero_o(rsp_zero), .rsp_carry_o(rsp_carry), .op_count_o(op_count)
    );

    alu_issue_ctrl #(.CNT_W(4)) dut_c4 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready4),
        .req_a_i(req_a), .req_b_i(req_b), .req_op_i(req_op),
        .alu_a_o(alu_a4), .alu_b_o(alu_b4), .alu_op_o(alu_op4), .alu_en_o(alu_en4),
        .alu_result_i(alu_result), .alu_carry_i(alu_carry),
        .rsp_valid_o(rsp_valid4), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result4),
        .rsp_zero_o(rsp_zero4), .rsp_carry_o(rsp_carry4), .op_count_o(op_count4)
    );

    // Returns {carry, result}: carry is carry-out for ADD, borrow for SUB, 0 otherwise.
    function automatic logic [16:0] alu_fn(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
        logic [31:0] p;
        case (op)
            3'd0: return {1'b0, a} + {1'b0, b};
            3'd1: return {1'b0, a} - {1'b0, b};
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a ^ b};
            3'd5: return {1'b0, a << b[3:0]};
            3'd6: return {1'b0, a >> b[3:0]};
            default: begin
                p = a * b;
                return {1'b0, p[15:0]};
            end
        endcase
    endfunction

    // Stand-in ALU: registers its result only on enabled cycles.
    always @(posedge clk) begin
        if (alu_en) {alu_carry, alu_result} <= alu_fn(alu_op, alu_a, alu_b);
    end

    int errors = 0;
    int checks = 0;
    int accepts = 0;
    int en_pulses = 0;
    int cnt16 = 0;
    int cnt4 = 0;
    logic prev_en = 1'b0;
    logic [16:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Enable pulse width and operand isolation, sampled on every falling edge.
    always @(negedge clk) begin
        if (alu_en) begin
            if (!prev_en) en_pulses++;
            check("en_width", {31'd0, prev_en}, 32'd0);
            check("ready_in_issue", {31'd0, req_ready}, 32'd0);
        end else begin
            check("iso_a", {16'd0, alu_a}, 32'd0);
            check("iso_b", {16'd0, alu_b}, 32'd0);
        end
        prev_en = alu_en;
    end

    task automatic do_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input int hold, input bit chk_lat);
        int i;
        logic [16:0] e;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        i = 0;
        while (!req_ready && i < 20) begin @(negedge clk); i++; end
        if (!req_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        accepts++;
        cnt16 = (cnt16 == 65535) ? 65535 : cnt16 + 1;
        cnt4  = (cnt4 == 15) ? 15 : cnt4 + 1;
        exp_q.push_back(alu_fn(op, a, b));
        @(negedge clk);
        req_valid = 1'b0;
        req_a = 16'($urandom); req_b = 16'($urandom); req_op = 3'($urandom);
        check("issue_en", {31'd0, alu_en}, 32'd1);
        check("issue_a", {16'd0, alu_a}, {16'd0, a});
        check("issue_b", {16'd0, alu_b}, {16'd0, b});
        check("issue_op", {29'd0, alu_op}, {29'd0, op});
        i = 1;
        while (!rsp_valid && i < 20) begin @(negedge clk); i++; end
        if (!rsp_valid) begin
            check("rsp_timeout", 32'd0, 32'd1);
            return;
        end
        if (chk_lat) check("latency", i - 1, 32'd3);
        e = exp_q.pop_front();
        check("rsp_result", {16'd0, rsp_result}, {16'd0, e[15:0]});
        check("rsp_zero", {31'd0, rsp_zero}, {31'd0, e[15:0] == 16'd0});
        check("rsp_carry", {31'd0, rsp_carry}, {31'd0, e[16]});
        check("op_count", {16'd0, op_count}, cnt16);
        check("op_count4", {28'd0, op_count4}, cnt4);
        repeat (hold) begin
            @(negedge clk);
            check("hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_result", {16'd0, rsp_result}, {16'd0, e[15:0]});
            check("hold_zero", {31'd0, rsp_zero}, {31'd0, e[15:0] == 16'd0});
            check("hold_carry", {31'd0, rsp_carry}, {31'd0, e[16]});
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
            check("hold_en", {31'd0, alu_en}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_dropped", {31'd0, rsp_valid}, 32'd0);
        check("kept_result", {16'd0, rsp_result}, {16'd0, e[15:0]});
    endtask

    initial begin
        int i;
        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_alu_en", {31'd0, alu_en}, 32'd0);
        check("rst_alu_op", {29'd0, alu_op}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_result", {16'd0, rsp_result}, 32'd0);
        check("rst_flags", {30'd0, rsp_zero, rsp_carry}, 32'd0);
        check("rst_op_count", {16'd0, op_count}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'd0, req_ready}, 32'd1);

        do_op(3'd0, 16'hFFFF, 16'h0001, 0, 1'b1);
        do_op(3'd1, 16'h0001, 16'h0002, 0, 1'b1);
        do_op(3'd7, 16'h0100, 16'h0100, 5, 1'b1);

        // Reset while the operation sits in WAIT.
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd0; req_a = 16'h1234; req_b = 16'h1111;
        i = 0;
        while (!req_ready && i < 20) begin @(negedge clk); i++; end
        check("wait_rst_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        accepts++;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cnt16 = 0; cnt4 = 0;
        check("wrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("wrst_alu_en", {31'd0, alu_en}, 32'd0);
        check("wrst_op_count", {16'd0, op_count}, 32'd0);
        check("wrst_op_count4", {28'd0, op_count4}, 32'd0);
        check("wrst_req_ready", {31'd0, req_ready}, 32'd0);
        repeat (6) begin
            @(negedge clk);
            check("wrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end

        for (int k = 0; k < 20; k++) begin
            do_op(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 0, 1'b1);
        end
        check("sat4_final", {28'd0, op_count4}, 32'd15);

        for (int k = 0; k < 50; k++) begin
            do_op(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                  int'($urandom_range(0, 2)), 1'b0);
        end
        repeat (3) @(negedge clk);
        check("en_pulses", en_pulses, accepts);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
